// File: rtl/dds_sine_gen.sv
// Direct-digital-synthesis sine source: phase accumulator, quarter-wave LUT with quadrant folding,
// ready/valid output stream. Define DDS_AMP_SCALE_EN to add an amplitude-scaling output stage.
module dds_sine_gen #(
    parameter int                         width_p        = 24,
    parameter int                         phase_width_p  = 32,
    parameter int                         lut_depth_lg_p = 8,
    parameter logic [phase_width_p-1:0]   step_reset_p   = 32'h0800_0000,
    parameter                             filename_p     = "sine_quarter.hex"
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          en_i,
    input  logic                          step_load_i,
    input  logic [phase_width_p-1:0]      step_i,
    input  logic                          phase_clr_i,
    input  logic [phase_width_p-1:0]      phase_offset_i,
    input  logic [15:0]                   amp_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic signed [width_p-1:0]     sine_o,
    output logic                          sync_o
);

    localparam int LG     = lut_depth_lg_p;
    localparam int PW     = phase_width_p;
    localparam int LUT_N  = 1 << LG;
    localparam int MAG_W  = width_p - 1;
    localparam logic [127:0] PI_Q60  = 128'h3243F6A8885A308D;
    localparam logic [127:0] MAG_MAX = (128'd1 << MAG_W) - 128'd1;

    // Table is computed at elaboration in Q60 fixed point; filename_p is kept only for interface compatibility.
    function automatic logic [MAG_W-1:0] quarter_sine(input int idx);
        logic [127:0] x, x2, term, acc, scaled;
        x    = (PI_Q60 * 128'(2 * idx + 1)) / 128'(4 * LUT_N);
        x2   = (x * x) >> 60;
        term = x;
        acc  = x;
        for (int k = 1; k <= 15; k++) begin
            term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
            if (k[0]) acc = acc - term;
            else      acc = acc + term;
        end
        scaled = acc * MAG_MAX + (128'd1 << 59);
        return scaled[60 +: MAG_W];
    endfunction

    logic [MAG_W-1:0] w_rom [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_rom
        assign w_rom[g] = quarter_sine(g);
    end

    // valid_o/ready_i: a sample transfers on an edge where both are high; while valid_o=1 and
    // ready_i=0 every stage holds, so sine_o and sync_o stay stable until accepted.
    logic w_advance;
    assign w_advance = ~valid_o | ready_i;

    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   r_step;
    logic            r_wrap;
    logic [PW:0]     w_sum;
    assign w_sum = {1'b0, r_phase} + {1'b0, r_step};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_phase <= '0;
            r_step  <= step_reset_p;
            r_wrap  <= 1'b0;
        end else begin
            if (step_load_i) r_step <= step_i;
            if (phase_clr_i) begin
                r_phase <= phase_offset_i;
                r_wrap  <= 1'b0;
            end else if (w_advance && en_i) begin
                r_phase <= w_sum[PW-1:0];
                r_wrap  <= w_sum[PW];
            end
        end
    end

    logic            r_s1_valid, r_s1_sync;
    logic [LG+1:0]   r_s1_phase;
    logic            r_s2_valid, r_s2_sync, r_s2_neg;
    logic [LG-1:0]   r_s2_addr;
    logic            r_smp_valid, r_smp_sync;
    logic signed [width_p-1:0] r_smp;

    logic [LG-1:0]   w_idx, w_fold;
    logic [MAG_W-1:0] w_mag;
    logic signed [width_p-1:0] w_pos, w_signed;
    assign w_idx    = r_s1_phase[LG-1:0];
    assign w_fold   = r_s1_phase[LG] ? ~w_idx : w_idx;
    assign w_mag    = w_rom[r_s2_addr];
    assign w_pos    = {1'b0, w_mag};
    assign w_signed = r_s2_neg ? -w_pos : w_pos;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_s1_valid  <= 1'b0;
            r_s1_sync   <= 1'b0;
            r_s1_phase  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_sync   <= 1'b0;
            r_s2_neg    <= 1'b0;
            r_s2_addr   <= '0;
            r_smp_valid <= 1'b0;
            r_smp_sync  <= 1'b0;
            r_smp       <= '0;
        end else if (w_advance) begin
            r_s1_valid  <= en_i;
            r_s1_sync   <= r_wrap;
            r_s1_phase  <= r_phase[PW-1 -: LG+2];
            r_s2_valid  <= r_s1_valid;
            r_s2_sync   <= r_s1_sync;
            r_s2_neg    <= r_s1_phase[LG+1];
            r_s2_addr   <= w_fold;
            r_smp_valid <= r_s2_valid;
            r_smp_sync  <= r_s2_valid & r_s2_sync;
            r_smp       <= w_signed;
        end
    end

    logic w_unused_cfg;
`ifdef DDS_AMP_SCALE_EN
    logic                      r_out_valid, r_out_sync;
    logic signed [width_p-1:0] r_out;
    logic signed [width_p+16:0] w_prod;
    assign w_prod = r_smp * $signed({1'b0, amp_i});

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_out_valid <= 1'b0;
            r_out_sync  <= 1'b0;
            r_out       <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_smp_valid;
            r_out_sync  <= r_smp_sync;
            r_out       <= w_prod[width_p+15:16];
        end
    end

    assign valid_o      = r_out_valid;
    assign sync_o       = r_out_sync;
    assign sine_o       = r_out;
    assign w_unused_cfg = ^filename_p;
`else
    assign valid_o      = r_smp_valid;
    assign sync_o       = r_smp_sync;
    assign sine_o       = r_smp;
    assign w_unused_cfg = ^{amp_i, ^filename_p};
`endif

endmodule

// File: tb/tb_dds_sine_gen.sv
// Bench for dds_sine_gen: randomized stimulus scored against a sine-formula reference model.
module tb_dds_sine_gen;

    localparam int W  = 24;
    localparam int PW = 32;
    localparam int LG = 8;
    localparam int N  = 256;
    localparam real AMPL   = 8388607.0;
    localparam real PI_R   = 3.14159265358979323846;
    localparam longint AMP = 32768;
`ifdef DDS_AMP_SCALE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          en_i = 1'b0;
    logic          step_load_i = 1'b0;
    logic [PW-1:0] step_i = '0;
    logic          phase_clr_i = 1'b0;
    logic [PW-1:0] phase_offset_i = '0;
    logic [15:0]   amp_i = '0;
    logic          ready_i = 1'b0;
    logic          valid_o;
    logic [W-1:0]  sine_o;
    logic          sync_o;

    dds_sine_gen dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_i), .step_load_i(step_load_i),
        .step_i(step_i), .phase_clr_i(phase_clr_i), .phase_offset_i(phase_offset_i),
        .amp_i(amp_i), .ready_i(ready_i), .valid_o(valid_o), .sine_o(sine_o), .sync_o(sync_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];
    logic model_on = 1'b0;
    logic mon_on = 1'b0;
    int accepted = 0;
    int first_sync = -1;
    logic stall_pend = 1'b0;
    logic [W:0] held = '0;

    logic [PW-1:0] m_phase = '0;
    logic [PW-1:0] m_step = 32'h0800_0000;
    logic          m_wrap = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] apply_amp(input longint v);
        longint r;
`ifdef DDS_AMP_SCALE_EN
        r = (v * AMP) >>> 16;
`else
        r = v;
`endif
        return r[W-1:0];
    endfunction

    function automatic longint lut_ref(input int i);
        real s;
        s = AMPL * $sin(PI_R / 2.0 * (real'(i) + 0.5) / real'(N));
        return longint'($rtoi(s + 0.5));
    endfunction

    // Full-period reference: sample the sine at the centre of the phase bucket.
    function automatic logic [W-1:0] ref_sine(input logic [PW-1:0] ph);
        int j;
        real s;
        longint v;
        j = int'(ph[PW-1 -: LG+2]);
        s = AMPL * $sin(2.0 * PI_R * (real'(j) + 0.5) / real'(4 * N));
        v = (s < 0.0) ? -longint'($rtoi(-s + 0.5)) : longint'($rtoi(s + 0.5));
        return apply_amp(v);
    endfunction

    task automatic model_edge(input logic en, input logic clr, input logic [PW-1:0] off,
                              input logic ld, input logic [PW-1:0] stp);
        logic [PW:0] sum;
        if (en) exp_q.push_back({m_wrap, ref_sine(m_phase)});
        if (clr) begin
            m_phase = off;
            m_wrap  = 1'b0;
        end else if (en) begin
            sum     = {1'b0, m_phase} + {1'b0, m_step};
            m_phase = sum[PW-1:0];
            m_wrap  = sum[PW];
        end
        if (ld) m_step = stp;
    endtask

    task automatic drive_amp();
`ifdef DDS_AMP_SCALE_EN
        amp_i = 16'(AMP);
`else
        amp_i = 16'($urandom);
`endif
    endtask

    task automatic cyc(input logic en, input logic clr, input logic [PW-1:0] off,
                       input logic ld, input logic [PW-1:0] stp);
        en_i = en; phase_clr_i = clr; phase_offset_i = off; step_load_i = ld; step_i = stp;
        drive_amp();
        if (model_on) model_edge(en, clr, off, ld, stp);
        @(posedge clk_i);
        #1;
        phase_clr_i = 1'b0;
        step_load_i = 1'b0;
    endtask

    task automatic quad_check(input logic [PW-1:0] off, input string tag);
        longint l0, l1, sgn;
        longint pat[4];
        l0  = lut_ref(0);
        l1  = lut_ref(N - 1);
        sgn = off[PW-1] ? -1 : 1;
        pat[0] = sgn * l0; pat[1] = sgn * l1; pat[2] = -sgn * l0; pat[3] = -sgn * l1;
        cyc(1'b1, 1'b1, off, 1'b1, 32'h4000_0000);
        for (int i = 0; i < 4; i++) begin
            repeat ((i == 0) ? LAT : 1) cyc(1'b1, 1'b0, '0, 1'b0, '0);
            check_eq({tag, "_valid"}, 64'(valid_o), 64'd1);
            check_eq(tag, 64'(sine_o), 64'(apply_amp(pat[i])));
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_on && reset_ni) begin
            if (stall_pend) begin
                check_eq("stall_valid", 64'(valid_o), 64'd1);
                check_eq("stall_data", 64'({sync_o, sine_o}), 64'(held));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_sample", 64'(valid_o), 64'd0);
                end else begin
                    check_eq("sample", 64'({sync_o, sine_o}), 64'(exp_q.pop_front()));
                    if (sync_o && first_sync < 0) first_sync <= accepted;
                    accepted <= accepted + 1;
                end
            end
            stall_pend <= valid_o && !ready_i;
            held       <= {sync_o, sine_o};
        end else begin
            stall_pend <= 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        logic [PW-1:0] r_off, r_stp;

        // Reset state, then default step from reset.
        en_i = 1'b1;
        ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_sine", 64'(sine_o), 64'd0);
        check_eq("rst_sync", 64'(sync_o), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        model_on = 1'b1;
        mon_on   = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            cyc(1'b1, 1'b0, '0, 1'b0, '0);
            check_eq("first_valid_lat", 64'(valid_o), 64'(e >= LAT));
        end
        repeat (40) cyc(1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("first_sync_idx", 64'(first_sync), 64'd32);

        // Quadrature step with simultaneous load and clear, then mid-stream clear.
        quad_check(32'h0000_0000, "quad");
        repeat (5) cyc(1'b1, 1'b0, '0, 1'b0, '0);
        quad_check(32'h8000_0000, "clr_mid");

        // Zero step holds the offset phase.
        cyc(1'b1, 1'b1, $urandom, 1'b1, '0);
        repeat (10) cyc(1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("step0_valid", 64'(valid_o), 64'd1);

        // Random enable, step loads and clears with ready held high.
        repeat (300) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom,
                ($urandom_range(0, 15) == 0), $urandom);
        end
        repeat (LAT + 2) cyc(1'b0, 1'b0, '0, 1'b0, '0);
        check_eq("drain_valid", 64'(valid_o), 64'd0);
        check_eq("q_empty_ready", 64'(exp_q.size()), 64'd0);

        // Random backpressure: accepted stream must equal the free-running sequence.
        for (int c = 0; c < 2; c++) begin
            r_off = (c == 0) ? 32'h0 : 32'($urandom);
            r_stp = (c == 0) ? 32'h4000_0000 : 32'($urandom);
            model_on = 1'b1;
            cyc(1'b0, 1'b1, r_off, 1'b1, r_stp);
            model_on = 1'b0;
            repeat (400) model_edge(1'b1, 1'b0, '0, 1'b0, '0);
            a0 = accepted;
            repeat (300) begin
                en_i = 1'b1;
                ready_i = 1'($urandom_range(0, 1));
                drive_amp();
                @(posedge clk_i);
                #1;
            end
            ready_i = 1'b1;
            repeat (LAT + 2) cyc(1'b0, 1'b0, '0, 1'b0, '0);
            check_eq("bp_drained", 64'(valid_o), 64'd0);
            check_eq("bp_accepted_nonzero", 64'(accepted > a0), 64'd1);
            exp_q.delete();
        end

        // One-cycle enable pulses: exactly one sample each.
        model_on = 1'b1;
        cyc(1'b0, 1'b1, $urandom, 1'b1, $urandom);
        a0 = accepted;
        repeat (12) begin
            cyc(1'b1, 1'b0, '0, 1'b0, '0);
            repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, '0);
        end
        repeat (LAT + 1) cyc(1'b0, 1'b0, '0, 1'b0, '0);
        check_eq("en_pulse_count", 64'(accepted - a0), 64'd12);
        check_eq("q_empty_pulse", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while stalled.
        mon_on = 1'b0;
        model_on = 1'b0;
        cyc(1'b1, 1'b1, 32'h1000_0000, 1'b1, 32'h0123_4567);
        repeat (LAT + 2) cyc(1'b1, 1'b0, '0, 1'b0, '0);
        ready_i = 1'b0;
        repeat (2) cyc(1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("pre_rst_valid", 64'(valid_o), 64'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(valid_o), 64'd0);
        check_eq("async_rst_sine", 64'(sine_o), 64'd0);
        check_eq("async_rst_sync", 64'(sync_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
